fifo_rewind: RTL and testbench

Parametrised successor of the command FIFO that sits between the host write path and buf_executor. It keeps the synchronous FIFO core and adds a selectable read mode (registered or first-word-fall-through), programmable almost-full/almost-empty flags, overflow/underflow pulses and a read checkpoint. With the checkpoint, buf_executor can mark a program start and replay the buffered commands after an abort without the host rewriting them.

---
 rtl/fifo_rewind.sv | 103 ++++++++++
 tb/tb_fifo_rewind.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rewind.sv
// Command FIFO between the host write path and buf_executor, with selectable read timing,
// programmable level flags and a read checkpoint that lets a program be replayed after an abort.
module fifo_rewind #(
    parameter int ADDRESS_WIDTH = 4,
    parameter int DATA_WIDTH    = 40,
    parameter bit FWFT          = 1'b0,
    parameter int AFULL_LEVEL   = (1 << ADDRESS_WIDTH) - 2,
    parameter int AEMPTY_LEVEL  = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [DATA_WIDTH-1:0]    write_data,
    input  logic                     write,
    input  logic                     read,
    input  logic                     mark,
    input  logic                     release_ckpt,
    input  logic                     rewind,
    output logic [DATA_WIDTH-1:0]    read_data,
    output logic                     empty,
    output logic                     full,
    output logic                     almost_full,
    output logic                     almost_empty,
    output logic [ADDRESS_WIDTH:0]   data_count,
    output logic [ADDRESS_WIDTH:0]   occupancy,
    output logic                     ckpt_active,
    output logic                     overflow,
    output logic                     underflow
);
    localparam int                   DEPTH    = 1 << ADDRESS_WIDTH;
    localparam logic [ADDRESS_WIDTH:0] DEPTH_P  = (ADDRESS_WIDTH+1)'(DEPTH);
    localparam logic [ADDRESS_WIDTH:0] AFULL_P  = (ADDRESS_WIDTH+1)'(AFULL_LEVEL);
    localparam logic [ADDRESS_WIDTH:0] AEMPTY_P = (ADDRESS_WIDTH+1)'(AEMPTY_LEVEL);

    logic [DATA_WIDTH-1:0]  mem [DEPTH];
    logic [ADDRESS_WIDTH:0] wr_ptr, rd_ptr, ckpt_ptr, base_ptr;
    logic                   ckpt_q, overflow_q, underflow_q;
    logic                   do_write, do_read;

    // Entries between base_ptr and rd_ptr are retained for replay, so they count as used slots.
    assign base_ptr     = ckpt_q ? ckpt_ptr : rd_ptr;
    assign data_count   = wr_ptr - rd_ptr;
    assign occupancy    = wr_ptr - base_ptr;
    assign empty        = (data_count == '0);
    assign full         = (occupancy == DEPTH_P);
    assign almost_full  = (occupancy >= AFULL_P);
    assign almost_empty = (data_count <= AEMPTY_P);
    assign ckpt_active  = ckpt_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

    assign do_write = write && !full;
    assign do_read  = read && !empty && !rewind;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            ckpt_ptr    <= '0;
            ckpt_q      <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= write && full;
            underflow_q <= read && empty && !rewind;
            if (do_write)
                wr_ptr <= wr_ptr + 1'b1;
            // Rewind outranks mark and release; a rewind with no checkpoint changes nothing.
            if (rewind) begin
                if (ckpt_q)
                    rd_ptr <= ckpt_ptr;
            end else begin
                if (do_read)
                    rd_ptr <= rd_ptr + 1'b1;
                if (mark) begin
                    ckpt_ptr <= rd_ptr;
                    ckpt_q   <= 1'b1;
                end else if (release_ckpt) begin
                    ckpt_q   <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_write && !reset)
            mem[wr_ptr[ADDRESS_WIDTH-1:0]] <= write_data;
    end

    generate
        if (FWFT) begin : g_fwft
            assign read_data = mem[rd_ptr[ADDRESS_WIDTH-1:0]];
        end else begin : g_reg
            logic [DATA_WIDTH-1:0] rdata_q;
            always_ff @(posedge clk) begin
                if (reset)
                    rdata_q <= '0;
                else if (do_read)
                    rdata_q <= mem[rd_ptr[ADDRESS_WIDTH-1:0]];
            end
            assign read_data = rdata_q;
        end
    endgenerate
endmodule

// File: tb/tb_fifo_rewind.sv
// Drives a registered-read and a fall-through instance with identical stimulus and checks
// both against an unbounded-pointer reference model of the FIFO with checkpoint.
module tb_fifo_rewind;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [39:0] write_data = '0;
    logic        write = 1'b0, read = 1'b0, mark = 1'b0, release_ckpt = 1'b0, rewind = 1'b0;

    logic [39:0] rdata0, rdata1;
    logic        empty0, full0, af0, ae0, ck0, ovf0, unf0;
    logic        empty1, full1, af1, ae1, ck1, ovf1, unf1;
    logic [4:0]  cnt0, occ0, cnt1, occ1;
    logic [16:0] status0, status1;

    int n_chk = 0;
    int n_fail = 0;

    // Reference model: absolute (never wrapping) positions into an unbounded history.
    int          m_wr, m_rd, m_ck;
    bit          m_act, m_ovf, m_unf;
    logic [39:0] m_rq;
    logic [39:0] hist [int];

    always #5 clk = ~clk;

    fifo_rewind #(.ADDRESS_WIDTH(4), .DATA_WIDTH(40), .FWFT(1'b0)) u_reg (
        .clk(clk), .reset(reset), .write_data(write_data), .write(write), .read(read),
        .mark(mark), .release_ckpt(release_ckpt), .rewind(rewind), .read_data(rdata0),
        .empty(empty0), .full(full0), .almost_full(af0), .almost_empty(ae0),
        .data_count(cnt0), .occupancy(occ0), .ckpt_active(ck0), .overflow(ovf0), .underflow(unf0)
    );

    fifo_rewind #(.ADDRESS_WIDTH(4), .DATA_WIDTH(40), .FWFT(1'b1)) u_fwft (
        .clk(clk), .reset(reset), .write_data(write_data), .write(write), .read(read),
        .mark(mark), .release_ckpt(release_ckpt), .rewind(rewind), .read_data(rdata1),
        .empty(empty1), .full(full1), .almost_full(af1), .almost_empty(ae1),
        .data_count(cnt1), .occupancy(occ1), .ckpt_active(ck1), .overflow(ovf1), .underflow(unf1)
    );

    assign status0 = {empty0, full0, af0, ae0, cnt0, occ0, ck0, ovf0, unf0};
    assign status1 = {empty1, full1, af1, ae1, cnt1, occ1, ck1, ovf1, unf1};

    function automatic logic [16:0] exp_status();
        int cnt, occ;
        cnt = m_wr - m_rd;
        occ = m_wr - (m_act ? m_ck : m_rd);
        return {cnt == 0, occ == 16, occ >= 14, cnt <= 1, 5'(cnt), 5'(occ), m_act, m_ovf, m_unf};
    endfunction

    function automatic logic [39:0] exp_head();
        return (m_wr > m_rd) ? hist[m_rd] : '0;
    endfunction

    task automatic do_reset();
        reset = 1'b1; write = 1'b1; read = 1'b1; mark = 1'b1; rewind = 1'b0; release_ckpt = 1'b0;
        write_data = 40'hDEADBEEF01;
        @(posedge clk);
        m_wr = 0; m_rd = 0; m_ck = 0; m_act = 0; m_ovf = 0; m_unf = 0; m_rq = '0;
        #1;
        reset = 1'b0; write = 1'b0; read = 1'b0; mark = 1'b0;
    endtask

    task automatic cycle(input bit w, input logic [39:0] wd, input bit r, input bit m,
                         input bit rl, input bit rw);
        int cnt, occ, rd_old;
        write = w; write_data = wd; read = r; mark = m; release_ckpt = rl; rewind = rw;
        cnt = m_wr - m_rd;
        occ = m_wr - (m_act ? m_ck : m_rd);
        rd_old = m_rd;
        @(posedge clk);
        m_ovf = w && (occ == 16);
        m_unf = r && (cnt == 0) && !rw;
        if (w && occ < 16) begin
            hist[m_wr] = wd;
            m_wr++;
        end
        if (rw) begin
            if (m_act) m_rd = m_ck;
        end else begin
            if (r && cnt > 0) begin
                m_rq = hist[rd_old];
                m_rd++;
            end
            if (m) begin
                m_ck = rd_old;
                m_act = 1;
            end else if (rl) begin
                m_act = 0;
            end
        end
        #1;
        write = 0; read = 0; mark = 0; release_ckpt = 0; rewind = 0;
    endtask

    task automatic test_reset();
        do_reset();
        cycle(1, 40'h1111111111, 0, 0, 0, 0);
        cycle(1, 40'h2222222222, 1, 1, 0, 0);
        do_reset();
        n_chk++;
        if (status0 !== 17'b1_0_0_1_00000_00000_0_0_0) begin
            n_fail++; $display("FAIL reset_status got %b exp %b", status0, 17'b1_0_0_1_00000_00000_0_0_0);
        end
        n_chk++;
        if (rdata0 !== 40'h0) begin
            n_fail++; $display("FAIL reset_rdata got %h exp 0", rdata0);
        end
    endtask

    task automatic test_basic();
        do_reset();
        cycle(1, 40'h8000000000, 0, 0, 0, 0);
        n_chk++;
        if (empty0 !== 1'b0) begin n_fail++; $display("FAIL basic_empty got %b exp 0", empty0); end
        cycle(1, 40'hBF00000000, 0, 0, 0, 0);
        n_chk++;
        if (cnt0 !== 5'd2) begin n_fail++; $display("FAIL basic_cnt2 got %0d exp 2", cnt0); end
        cycle(0, '0, 1, 0, 0, 0);
        n_chk++;
        if (rdata0 !== 40'h8000000000 || cnt0 !== 5'd1) begin
            n_fail++; $display("FAIL basic_pop1 got %h/%0d exp 8000000000/1", rdata0, cnt0);
        end
        cycle(0, '0, 1, 0, 0, 0);
        n_chk++;
        if (rdata0 !== 40'hBF00000000 || cnt0 !== 5'd0 || empty0 !== 1'b1) begin
            n_fail++; $display("FAIL basic_pop2 got %h/%0d/%b exp BF00000000/0/1", rdata0, cnt0, empty0);
        end
        cycle(0, '0, 0, 0, 0, 0);
        n_chk++;
        if (rdata0 !== 40'hBF00000000) begin n_fail++; $display("FAIL basic_hold got %h exp BF00000000", rdata0); end
    endtask

    task automatic test_fill();
        do_reset();
        for (int i = 0; i < 16; i++) begin
            cycle(1, {8'(i), 32'hA5A50000 + 32'(i)}, 0, 0, 0, 0);
            n_chk++;
            if (af0 !== (i + 1 >= 14) || status0 !== exp_status()) begin
                n_fail++; $display("FAIL fill_%0d got %b exp %b", i, status0, exp_status());
            end
        end
        n_chk++;
        if (full0 !== 1'b1) begin n_fail++; $display("FAIL fill_full got %b exp 1", full0); end
        cycle(1, 40'h7777777777, 0, 0, 0, 0);
        n_chk++;
        if (ovf0 !== 1'b1 || cnt0 !== 5'd16) begin
            n_fail++; $display("FAIL fill_overflow got %b/%0d exp 1/16", ovf0, cnt0);
        end
        cycle(1, 40'h6666666666, 1, 0, 0, 0);
        n_chk++;
        if (cnt0 !== 5'd15 || ovf0 !== 1'b1 || rdata0 !== {8'd0, 32'hA5A50000}) begin
            n_fail++; $display("FAIL fill_rw_full got %0d/%b/%h exp 15/1/00a5a50000", cnt0, ovf0, rdata0);
        end
        cycle(0, '0, 0, 0, 0, 0);
        n_chk++;
        if (ovf0 !== 1'b0) begin n_fail++; $display("FAIL fill_ovf_pulse got %b exp 0", ovf0); end
    endtask

    task automatic test_underflow();
        do_reset();
        cycle(0, '0, 1, 0, 0, 0);
        n_chk++;
        if (unf0 !== 1'b1 || status0 !== exp_status()) begin
            n_fail++; $display("FAIL unf_empty got %b exp %b", status0, exp_status());
        end
        cycle(1, 40'h1234512345, 1, 0, 0, 0);
        n_chk++;
        if (cnt0 !== 5'd1 || unf0 !== 1'b1) begin
            n_fail++; $display("FAIL unf_rw_empty got %0d/%b exp 1/1", cnt0, unf0);
        end
        cycle(0, '0, 0, 0, 0, 0);
        n_chk++;
        if (unf0 !== 1'b0) begin n_fail++; $display("FAIL unf_pulse got %b exp 0", unf0); end
    endtask

    task automatic test_rewind();
        logic [39:0] words [3];
        words[0] = 40'h8500000008; words[1] = 40'h8600000010; words[2] = 40'h8808070605;
        do_reset();
        for (int i = 0; i < 3; i++) cycle(1, words[i], 0, 0, 0, 0);
        cycle(0, '0, 0, 1, 0, 0);
        for (int i = 0; i < 3; i++) begin
            cycle(0, '0, 1, 0, 0, 0);
            n_chk++;
            if (rdata0 !== words[i]) begin n_fail++; $display("FAIL rw_read%0d got %h exp %h", i, rdata0, words[i]); end
        end
        cycle(0, '0, 0, 0, 0, 1);
        n_chk++;
        if (cnt0 !== 5'd3 || ck0 !== 1'b1 || occ0 !== 5'd3) begin
            n_fail++; $display("FAIL rw_restore got %0d/%b/%0d exp 3/1/3", cnt0, ck0, occ0);
        end
        for (int i = 0; i < 3; i++) begin
            cycle(0, '0, 1, 0, 0, 0);
            n_chk++;
            if (rdata0 !== words[i]) begin n_fail++; $display("FAIL rw_reread%0d got %h exp %h", i, rdata0, words[i]); end
        end
    endtask

    task automatic test_ckpt_full();
        do_reset();
        cycle(0, '0, 0, 1, 0, 0);
        for (int i = 0; i < 16; i++) cycle(1, 40'hC000000000 + 40'(i), 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) cycle(0, '0, 1, 0, 0, 0);
        n_chk++;
        if (full0 !== 1'b1 || cnt0 !== 5'd6 || occ0 !== 5'd16) begin
            n_fail++; $display("FAIL ck_full got %b/%0d/%0d exp 1/6/16", full0, cnt0, occ0);
        end
        cycle(1, 40'hEEEEEEEEEE, 0, 0, 0, 0);
        n_chk++;
        if (ovf0 !== 1'b1 || cnt0 !== 5'd6) begin n_fail++; $display("FAIL ck_ovf got %b/%0d exp 1/6", ovf0, cnt0); end
        cycle(0, '0, 0, 0, 1, 0);
        n_chk++;
        if (full0 !== 1'b0 || occ0 !== 5'd6 || ck0 !== 1'b0) begin
            n_fail++; $display("FAIL ck_release got %b/%0d/%b exp 0/6/0", full0, occ0, ck0);
        end
        cycle(1, 40'hFFFFFFFFF0, 0, 0, 0, 0);
        n_chk++;
        if (cnt0 !== 5'd7 || ovf0 !== 1'b0 || status0 !== exp_status()) begin
            n_fail++; $display("FAIL ck_accept got %b exp %b", status0, exp_status());
        end
    endtask

    task automatic test_fwft();
        do_reset();
        cycle(1, 40'h8300000001, 0, 0, 0, 0);
        n_chk++;
        if (rdata1 !== 40'h8300000001 || empty1 !== 1'b0) begin
            n_fail++; $display("FAIL fwft_head got %h/%b exp 8300000001/0", rdata1, empty1);
        end
        cycle(0, '0, 1, 1, 0, 1);
        n_chk++;
        if (cnt1 !== 5'd1 || unf1 !== 1'b0 || ck1 !== 1'b0 || rdata1 !== 40'h8300000001) begin
            n_fail++; $display("FAIL fwft_rewind_prio got %0d/%b/%b/%h exp 1/0/0/8300000001", cnt1, unf1, ck1, rdata1);
        end
        for (int i = 0; i < 40; i++) begin
            cycle(1, {8'h90, 32'(i * 7 + 3)}, 1, 0, 0, 0);
            n_chk++;
            if (cnt1 !== 5'd1 || rdata1 !== exp_head() || rdata0 !== m_rq) begin
                n_fail++; $display("FAIL fwft_wrap%0d got %0d/%h/%h exp 1/%h/%h", i, cnt1, rdata1, rdata0, exp_head(), m_rq);
            end
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 600; i++) begin
            cycle($urandom_range(0, 9) < 6, {8'($urandom), 32'($urandom)}, $urandom_range(0, 9) < 5,
                  $urandom_range(0, 19) == 0, $urandom_range(0, 11) == 0, $urandom_range(0, 19) == 0);
            n_chk++;
            if (status0 !== exp_status() || status1 !== exp_status() || rdata0 !== m_rq ||
                (m_wr > m_rd && rdata1 !== exp_head())) begin
                n_fail++;
                $display("FAIL random%0d got %b/%b/%h/%h exp %b/%h/%h", i, status0, status1, rdata0, rdata1,
                         exp_status(), m_rq, exp_head());
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_fill();
        test_underflow();
        test_rewind();
        test_ckpt_full();
        test_fwft();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
